// File: rtl/cook_entry_ctrl_if.sv
// rtl/cook_entry_ctrl_if.sv - keypad/datapath signal bundle for the cook entry controller
interface cook_entry_ctrl_if;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic        doneIn;
  logic [15:0] oDuration;
  logic [1:0]  oHeatingLevel;
  logic        oLoadDuration;
  logic        oLoadHeat;
  logic        oStart;
  logic        oControlReset;
  logic [2:0]  oDigitCount;
  logic        oFinished;

  modport master (
    output keyValid, keyCode, doneIn,
    input  oDuration, oHeatingLevel, oLoadDuration, oLoadHeat,
           oStart, oControlReset, oDigitCount, oFinished
  );

  modport slave (
    input  keyValid, keyCode, doneIn,
    output oDuration, oHeatingLevel, oLoadDuration, oLoadHeat,
           oStart, oControlReset, oDigitCount, oFinished
  );
endinterface

// File: rtl/cook_entry_ctrl.sv
// rtl/cook_entry_ctrl.sv - microwave keypad entry FSM: BCD time entry, heat select, start/abort/done sequencing
module cook_entry_ctrl #(
  parameter int KEY_DIGIT_MAX = 9
) (
  input logic              clock,
  input logic              reset,
  cook_entry_ctrl_if.slave bus
);

  localparam logic [3:0] DIGIT_MAX = 4'(KEY_DIGIT_MAX);
  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_START = 4'd11;
  localparam logic [3:0] KEY_HEAT  = 4'd12;

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_LOAD, S_RUN, S_DONE} state_t;

  state_t      state, state_n;
  logic [15:0] dur_n;
  logic [1:0]  heat_n;
  logic [2:0]  cnt_n;
  logic        creset_n;
  logic        run_first, run_first_n;

  logic key_ok, key_digit, key_clear, key_start, key_heat;

  // Reserved codes 13-15 never qualify as a key anywhere
  assign key_ok    = bus.keyValid && (bus.keyCode <= KEY_HEAT);
  assign key_digit = key_ok && (bus.keyCode <= DIGIT_MAX);
  assign key_clear = key_ok && (bus.keyCode == KEY_CLEAR);
  assign key_start = key_ok && (bus.keyCode == KEY_START);
  assign key_heat  = key_ok && (bus.keyCode == KEY_HEAT);

  always_comb begin
    state_n     = state;
    dur_n       = bus.oDuration;
    heat_n      = bus.oHeatingLevel;
    cnt_n       = bus.oDigitCount;
    creset_n    = 1'b0;
    run_first_n = 1'b0;
    case (state)
      S_IDLE, S_ENTRY: begin
        if (key_digit) begin
          if (bus.oDigitCount < 3'd4) begin
            dur_n   = {bus.oDuration[11:0], bus.keyCode};
            cnt_n   = bus.oDigitCount + 3'd1;
            state_n = S_ENTRY;
          end
        end else if (key_heat) begin
          heat_n = bus.oHeatingLevel + 2'd1;
        end else if (key_clear) begin
          if (state == S_ENTRY) begin
            dur_n   = 16'h0000;
            cnt_n   = 3'd0;
            state_n = S_IDLE;
          end
        end else if (key_start && (bus.oDuration != 16'h0000)) begin
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        state_n     = S_RUN;
        run_first_n = 1'b1;
      end
      S_RUN: begin
        // Abort wins over a coincident done flag
        if (key_clear) begin
          creset_n = 1'b1;
          dur_n    = 16'h0000;
          cnt_n    = 3'd0;
          state_n  = S_IDLE;
        end else if (bus.doneIn && !run_first) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (key_ok) begin
          dur_n   = 16'h0000;
          cnt_n   = 3'd0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      run_first         <= 1'b0;
      bus.oDuration     <= 16'h0000;
      bus.oHeatingLevel <= 2'b00;
      bus.oDigitCount   <= 3'd0;
      bus.oLoadDuration <= 1'b0;
      bus.oLoadHeat     <= 1'b0;
      bus.oStart        <= 1'b0;
      bus.oControlReset <= 1'b0;
      bus.oFinished     <= 1'b0;
    end else begin
      state             <= state_n;
      run_first         <= run_first_n;
      bus.oDuration     <= dur_n;
      bus.oHeatingLevel <= heat_n;
      bus.oDigitCount   <= cnt_n;
      bus.oLoadDuration <= (state_n == S_LOAD);
      bus.oLoadHeat     <= (state_n == S_LOAD);
      bus.oStart        <= (state_n == S_RUN);
      bus.oControlReset <= creset_n;
      bus.oFinished     <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_cook_entry_ctrl.sv
// tb/tb_cook_entry_ctrl.sv - directed self-checking bench for cook_entry_ctrl
module tb_cook_entry_ctrl;
  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  cook_entry_ctrl_if bus ();

  cook_entry_ctrl #(.KEY_DIGIT_MAX(9)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present inputs at the falling edge, sample 1ns after the next rising edge
  task automatic step(input logic kv, input logic [3:0] kc, input logic dn);
    @(negedge clock);
    bus.keyValid = kv;
    bus.keyCode  = kc;
    bus.doneIn   = dn;
    @(posedge clock);
    #1;
  endtask

  task automatic key(input logic [3:0] kc);
    step(1'b1, kc, 1'b0);
  endtask

  task automatic chk_all(input string tag, input logic [15:0] d, input logic [1:0] h,
                         input logic [2:0] c, input logic ld, input logic st,
                         input logic cr, input logic fn);
    chk({tag, ".dur"},    32'(bus.oDuration),     32'(d));
    chk({tag, ".heat"},   32'(bus.oHeatingLevel), 32'(h));
    chk({tag, ".cnt"},    32'(bus.oDigitCount),   32'(c));
    chk({tag, ".ldur"},   32'(bus.oLoadDuration), 32'(ld));
    chk({tag, ".lheat"},  32'(bus.oLoadHeat),     32'(ld));
    chk({tag, ".start"},  32'(bus.oStart),        32'(st));
    chk({tag, ".creset"}, 32'(bus.oControlReset), 32'(cr));
    chk({tag, ".fin"},    32'(bus.oFinished),     32'(fn));
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    bus.keyValid = 1'b0;
    bus.keyCode  = 4'd0;
    bus.doneIn   = 1'b0;
    #12;
    chk_all("reset", 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Heat wraps modulo 4: five presses end at level 1
    key(4'd12); key(4'd12); key(4'd12);
    chk("heat3", 32'(bus.oHeatingLevel), 32'd3);
    key(4'd12);
    chk("heat_wrap", 32'(bus.oHeatingLevel), 32'd0);
    key(4'd12);
    chk_all("heat5", 16'h0000, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    key(4'd10);
    chk_all("idle_clear", 16'h0000, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    key(4'd11);
    chk_all("start_zero", 16'h0000, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk_all("start_zero2", 16'h0000, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    key(4'd14);
    chk_all("idle_rsvd", 16'h0000, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Digit entry with fifth digit dropped
    key(4'd1);
    chk("d1.dur", 32'(bus.oDuration), 32'h0001);
    chk("d1.cnt", 32'(bus.oDigitCount), 32'd1);
    key(4'd3); key(4'd0); key(4'd5);
    chk("d4.dur", 32'(bus.oDuration), 32'h1305);
    chk("d4.cnt", 32'(bus.oDigitCount), 32'd4);
    key(4'd7);
    chk_all("d5_drop", 16'h1305, 2'd1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    key(4'd12);
    chk_all("entry_heat", 16'h1305, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    key(4'd14);
    chk_all("entry_rsvd", 16'h1305, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    key(4'd10);
    chk_all("entry_clear", 16'h0000, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start handshake, done masked in LOAD and first RUN cycle
    key(4'd4); key(4'd5);
    chk("d45.dur", 32'(bus.oDuration), 32'h0045);
    key(4'd11);
    chk_all("load", 16'h0045, 2'd2, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b1);
    chk_all("run1", 16'h0045, 2'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd12, 1'b1);
    chk_all("run2", 16'h0045, 2'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    chk_all("done", 16'h0045, 2'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd14, 1'b0);
    chk_all("done_rsvd", 16'h0045, 2'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    key(4'd3);
    chk_all("done_exit", 16'h0000, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk_all("done_exit2", 16'h0000, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // CLEAR coinciding with doneIn in RUN takes the abort path
    key(4'd2); key(4'd11);
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk("sim.run", 32'(bus.oStart), 32'd1);
    step(1'b1, 4'd10, 1'b1);
    chk_all("sim_abort", 16'h0000, 2'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk_all("sim_after", 16'h0000, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Plain abort in the first RUN cycle
    key(4'd6); key(4'd11);
    step(1'b0, 4'd0, 1'b0);
    chk("abort.run", 32'(bus.oStart), 32'd1);
    key(4'd10);
    chk_all("abort", 16'h0000, 2'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk("abort.pulse", 32'(bus.oControlReset), 32'd0);

    // Asynchronous reset mid-RUN
    key(4'd8); key(4'd11);
    step(1'b0, 4'd0, 1'b0);
    chk("rst.run", 32'(bus.oStart), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_all("rst_mid", 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    key(4'd7);
    chk_all("post_rst", 16'h0007, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cook_entry_ctrl.md
COOK_ENTRY_CTRL -- requirements
Module: cook_entry_ctrl

Interface
REQ-001 SHALL have parameter KEY_DIGIT_MAX, default 9, meaning the highest keyCode treated as a digit.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port keyValid  input  1  one-cycle strobe qualifying keyCode.
REQ-005 SHALL have port keyCode  input  4  key value:
  - 0-9 digit
  - 10 CLEAR
  - 11 START
  - 12 HEAT
  - 13-15 reserved
REQ-006 SHALL have port doneIn  input  1  cook-complete flag from the microwave datapath.
REQ-007 SHALL have port oDuration  output  16  BCD cook time {min10, min1, sec10, sec1}.
REQ-008 SHALL have port oHeatingLevel  output  2  selected heat level.
REQ-009 SHALL have port oLoadDuration  output  1  one-cycle load strobe for the duration register.
REQ-010 SHALL have port oLoadHeat  output  1  one-cycle load strobe for the heat register.
REQ-011 SHALL have port oStart  output  1  level; high while cooking is requested.
REQ-012 SHALL have port oControlReset  output  1  one-cycle abort strobe to the datapath.
REQ-013 SHALL have port oDigitCount  output  3  number of digits entered, 0-4.
REQ-014 SHALL have port oFinished  output  1  level; high in state DONE.

Function
REQ-015 SHALL implement states IDLE, ENTRY, LOAD, RUN, DONE; keyValid is acted on at most once per cycle.
REQ-016 SHALL ignore reserved codes 13-15 in every state, with no state or output change.
REQ-017 IDLE and ENTRY, digit key d: if oDigitCount<4, oDuration<={oDuration[11:0],d}, oDigitCount+1, state ENTRY.
REQ-018 IDLE and ENTRY, digit key with oDigitCount==4: key ignored; the fifth digit is dropped.
REQ-019 IDLE and ENTRY, HEAT key: oHeatingLevel increments modulo 4 (3 wraps to 0); no other change.
REQ-020 ENTRY, CLEAR key: oDuration=0, oDigitCount=0, state IDLE; oHeatingLevel is unchanged.
REQ-021 IDLE, CLEAR key: no effect.
REQ-022 IDLE and ENTRY, START key with oDuration==0: ignored.
REQ-023 IDLE and ENTRY, START key with oDuration!=0: state LOAD on the next cycle.
REQ-024 All BCD digit values 0-9 SHALL be accepted in every position; seconds 60-99 are legal (max 99:99).
REQ-025 LOAD: oLoadDuration=1 and oLoadHeat=1 for exactly one cycle, then RUN; keys in LOAD are ignored.
REQ-026 RUN: oStart=1 and oDuration/oHeatingLevel held stable.
REQ-027 RUN: digit, HEAT and START keys ignored.
REQ-028 RUN: doneIn is ignored in the first RUN cycle (load-settling mask).
REQ-029 RUN, from the second cycle, doneIn=1: state DONE, oStart=0.
REQ-030 RUN, CLEAR key: oControlReset=1 for one cycle, oStart=0, oDuration=0, oDigitCount=0, state IDLE.
REQ-031 RUN: simultaneous CLEAR and doneIn SHALL take the CLEAR path (REQ-030).
REQ-032 DONE: oFinished=1, oStart=0, and the state persists until any valid key (0-12).
REQ-033 DONE, on a valid key: oDuration=0, oDigitCount=0, oFinished=0, state IDLE; the key is consumed and not applied.
REQ-034 oLoadDuration, oLoadHeat and oControlReset SHALL be registered and never high in the same cycle as one another's non-LOAD cause.
REQ-035 oLoadDuration and oLoadHeat SHALL never assert outside LOAD.
REQ-036 All outputs SHALL be registered (no combinational key-to-output path); latency key to output is 1 cycle.

Reset
REQ-037 On reset low, asynchronously: state IDLE, oDuration=16'h0000, oHeatingLevel=2'b00, oDigitCount=0, and oLoadDuration, oLoadHeat, oStart, oControlReset and oFinished all 0.
REQ-038 Reset asserted mid-RUN SHALL drop oStart immediately, without pulsing oControlReset.
REQ-039 After reset is released, the first rising edge SHALL process keys normally.

Verification
REQ-040 Entry: keys 1,3,0,5 -> oDuration=16'h1305, oDigitCount=4; then key 7 -> oDuration still 16'h1305.
REQ-041 Heat wrap: HEAT pressed 5 times from reset -> oHeatingLevel=1.
REQ-042 Start handshake:
  - Stimulus: digits 4,5 (16'h0045) then START.
  - Response: one cycle of oLoadDuration=oLoadHeat=1, then oStart=1.
  - START with 16'h0000 -> no strobe, state IDLE.
REQ-043 Done and simultaneous events:
  - Stimulus: doneIn held 1 during the LOAD cycle and the first RUN cycle.
  - Response: oStart remains 1 in the first RUN cycle; DONE is entered on the second; then any key -> IDLE with oDuration=0.
  - CLEAR and doneIn in the same RUN cycle -> oControlReset pulse, IDLE, oFinished stays 0.
REQ-044 Abort and reset:
  - CLEAR in RUN -> one-cycle oControlReset, oStart=0, oDuration=0.
  - Reset low mid-RUN -> all outputs 0 with no oControlReset pulse.
  - Reserved code 14 in any state -> no change.
